seg7_scan_driver: RTL and testbench

- Downstream consumer of the cascaded mod-60 counter: takes the units BCD digit and the tens BCD digit and drives a 2-digit time-multiplexed common-anode 7-segment display.
- The tens digit comes from a ripple-clocked stage, so both inputs are double-registered and glitch-filtered before display.
- Values are snapshotted once per frame, so a digit never changes mid-frame.
- A dead-time (blanking) interval at each digit switch prevents ghosting.

---
 rtl/seg7_scan_driver.sv | 120 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed common-anode 7-segment driver fed by a BCD counter.
// Inputs are synchronised and glitch-filtered, snapshotted once per frame, and scanned with dead-time.
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  parameter bit LZ_BLANK  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] bcd_lo,
  input  logic [3:0] bcd_hi,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick,
  output logic       err
);

  localparam int DW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t        state_q, state_d;
  logic [7:0]    s1_q, s2_q, filt_q, disp_q, disp_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          slot_q, slot_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          frame_tick_q, err_q, err_d;
  logic          div_wrap, frame_start, lz_hide;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_pat;

  always_comb begin
    div_wrap    = (div_cnt_q == DW'(SCAN_DIV - 1));
    frame_start = en && (div_cnt_q == '0) && !slot_q;

    div_cnt_d = '0;
    slot_d    = 1'b0;
    if (en) begin
      div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
      slot_d    = slot_q ^ div_wrap;
    end

    disp_d = frame_start ? filt_q : disp_q;
    err_d  = err_q | (frame_start && ((filt_q[7:4] > 4'd9) || (filt_q[3:0] > 4'd9)));

    // Dropping en overrides every other transition, including a coincident wrap.
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = BLANK;
        BLANK:   if (div_cnt_d >= DW'(BLANK_CYC)) state_d = SHOW;
        SHOW:    if (div_wrap) state_d = BLANK;
        default: state_d = IDLE;
      endcase
    end

    // Decode from disp_d so the first cycle of a new frame already carries the new snapshot.
    cur_digit = slot_q ? disp_d[7:4] : disp_d[3:0];
    case (cur_digit)
      4'd0:    cur_pat = 7'h40;
      4'd1:    cur_pat = 7'h79;
      4'd2:    cur_pat = 7'h24;
      4'd3:    cur_pat = 7'h30;
      4'd4:    cur_pat = 7'h19;
      4'd5:    cur_pat = 7'h12;
      4'd6:    cur_pat = 7'h02;
      4'd7:    cur_pat = 7'h78;
      4'd8:    cur_pat = 7'h00;
      4'd9:    cur_pat = 7'h10;
      default: cur_pat = 7'h3F;
    endcase

    lz_hide = LZ_BLANK && slot_q && (cur_digit == 4'd0);
    seg_d   = 7'h7F;
    an_d    = 2'b11;
    if ((state_q != IDLE) && !lz_hide) begin
      seg_d = cur_pat;
      if (state_q == SHOW) an_d = slot_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      filt_q       <= '0;
      disp_q       <= '0;
      div_cnt_q    <= '0;
      slot_q       <= 1'b0;
      state_q      <= IDLE;
      seg_q        <= 7'h7F;
      an_q         <= 2'b11;
      frame_tick_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      s1_q <= {bcd_hi, bcd_lo};
      s2_q <= s1_q;
      // Accept a value only after it has been seen on two consecutive samples.
      if (s1_q == s2_q) filt_q <= s2_q;
      disp_q       <= disp_d;
      div_cnt_q    <= div_cnt_d;
      slot_q       <= slot_d;
      state_q      <= state_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_start;
      err_q        <= err_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;
  assign err        = err_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a positional scan model checked every cycle on two instances
// (leading-zero blanking on and off), plus directed frame windows with literal expectations.
module tb_seg7_scan_driver;

  localparam int SD = 8;
  localparam int BC = 2;

  logic       clk, rst, en;
  logic [3:0] bcd_lo, bcd_hi;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       tick_a, tick_b, err_a, err_b;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .bcd_lo(bcd_lo), .bcd_hi(bcd_hi),
    .seg(seg_a), .an(an_a), .frame_tick(tick_a), .err(err_a)
  );

  seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(1'b0)) dut_nlz (
    .clk(clk), .rst(rst), .en(en), .bcd_lo(bcd_lo), .bcd_hi(bcd_hi),
    .seg(seg_b), .an(an_b), .frame_tick(tick_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pattern(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Model: r counts consecutive enabled samples; frame position is plain arithmetic on r.
  int         r;
  logic [7:0] h1, h2, m_filt, m_disp;
  logic       m_err, m_tick;
  logic [6:0] m_seg[2];
  logic [1:0] m_an[2];

  always @(posedge clk or posedge rst) begin
    int         slot, pos;
    logic [3:0] dig;
    logic       fs;
    if (rst) begin
      r = 0; h1 = '0; h2 = '0; m_filt = '0; m_disp = '0; m_err = 1'b0; m_tick = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_seg[k] = 7'h7F;
        m_an[k]  = 2'b11;
      end
    end else begin
      fs = en && ((r % (2 * SD)) == 0);
      if (fs) begin
        m_disp = m_filt;
        if (m_filt[7:4] > 4'd9 || m_filt[3:0] > 4'd9) m_err = 1'b1;
      end
      m_tick = fs;
      for (int k = 0; k < 2; k++) begin
        m_seg[k] = 7'h7F;
        m_an[k]  = 2'b11;
      end
      if (r != 0) begin
        slot = (r / SD) % 2;
        pos  = r % SD;
        dig  = (slot == 1) ? m_disp[7:4] : m_disp[3:0];
        for (int k = 0; k < 2; k++) begin
          if (!(k == 0 && slot == 1 && dig == 4'd0)) begin
            m_seg[k] = pattern(dig);
            if (pos >= BC) m_an[k] = (slot == 1) ? 2'b01 : 2'b10;
          end
        end
      end
      if (h1 == h2) m_filt = h1;
      h2 = h1;
      h1 = {bcd_hi, bcd_lo};
      r  = en ? r + 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_seg_lz",  seg_a,  m_seg[0]);
      check("model_an_lz",   an_a,   m_an[0]);
      check("model_seg_nlz", seg_b,  m_seg[1]);
      check("model_an_nlz",  an_b,   m_an[1]);
      check("model_tick",    tick_a, m_tick);
      check("model_err",     err_a,  m_err);
      check("an_exclusive",  (an_a == 2'b00) || (an_b == 2'b00), 1'b0);
    end
  end

  // Frame capture: index 0 = LZ instance, 1 = no-LZ instance.
  logic [1:0] w_an[2][16];
  logic [6:0] w_seg[2][16];
  logic       w_tick[16];
  int         w_len;

  task automatic frame_window(input int n);
    w_len = n;
    for (int i = 0; i < n; i++) begin
      w_an[0][i] = an_a;  w_seg[0][i] = seg_a;
      w_an[1][i] = an_b;  w_seg[1][i] = seg_b;
      w_tick[i]  = tick_a;
      @(negedge clk);
    end
  endtask

  function automatic int wcount(input int inst, input logic [1:0] a, input logic [6:0] s);
    int c = 0;
    for (int i = 0; i < w_len; i++)
      if (w_an[inst][i] == a && w_seg[inst][i] == s) c++;
    return c;
  endfunction

  task automatic wait_tick();
    for (int i = 0; i < 64 && !tick_a; i++) @(negedge clk);
    check("tick_wait", tick_a, 1'b1);
  endtask

  task automatic next_frame();
    repeat (4) @(negedge clk);
    wait_tick();
  endtask

  task automatic set_bcd(input logic [3:0] hi, input logic [3:0] lo);
    bcd_hi = hi;
    bcd_lo = lo;
  endtask

  initial begin
    int n8;
    rst = 1'b0; en = 1'b0; set_bcd(4'd0, 4'd0);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset / idle with en low.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_seg", seg_a, 7'h7F);
      check("idle_an", an_a, 2'b11);
      check("idle_tick", tick_a, 1'b0);
      check("idle_err", err_a, 1'b0);
    end

    // Basic scan of 47; skip the first frame after IDLE.
    set_bcd(4'd4, 4'd7);
    repeat (4) @(negedge clk);
    en = 1'b1;
    wait_tick();
    @(negedge clk);
    wait_tick();
    frame_window(16);
    check("basic_u_blank", wcount(0, 2'b11, 7'h78), 2);
    check("basic_u_show",  wcount(0, 2'b10, 7'h78), 6);
    check("basic_t_blank", wcount(0, 2'b11, 7'h19), 2);
    check("basic_t_show",  wcount(0, 2'b01, 7'h19), 6);
    check("basic_tick_first", w_tick[0], 1'b1);
    n8 = 0;
    for (int i = 0; i < 16; i++) n8 += int'(w_tick[i]);
    check("basic_tick_count", n8, 1);
    check("basic_tick_period", tick_a, 1'b1);

    // Leading zero: 03.
    set_bcd(4'd0, 4'd3);
    next_frame();
    frame_window(16);
    check("lz_tens_dark",   wcount(0, 2'b11, 7'h7F), 8);
    check("lz_units_show",  wcount(0, 2'b10, 7'h30), 6);
    check("lz_units_blank", wcount(0, 2'b11, 7'h30), 2);
    check("nlz_tens_show",  wcount(1, 2'b01, 7'h40), 6);
    check("nlz_tens_blank", wcount(1, 2'b11, 7'h40), 2);

    // Frame-atomic update: 59 then 00 mid-frame.
    set_bcd(4'd5, 4'd9);
    next_frame();
    frame_window(16);
    check("f59_units", wcount(0, 2'b10, 7'h10), 6);
    check("f59_tens",  wcount(0, 2'b01, 7'h12), 6);
    repeat (3) @(negedge clk);
    set_bcd(4'd0, 4'd0);
    frame_window(13);
    check("atomic_units_kept", wcount(0, 2'b10, 7'h10), 5);
    check("atomic_tens_kept",  wcount(0, 2'b01, 7'h12), 6);
    check("atomic_tick", tick_a, 1'b1);
    frame_window(16);
    check("f00_units", wcount(0, 2'b10, 7'h40), 6);
    check("f00_tens_dark", wcount(0, 2'b11, 7'h7F), 8);

    // Glitch filter: a one-cycle 8 must never appear.
    set_bcd(4'd0, 4'd2);
    next_frame();
    frame_window(16);
    check("g2_units", wcount(0, 2'b10, 7'h24), 6);
    bcd_lo = 4'd8;
    @(negedge clk);
    bcd_lo = 4'd2;
    n8 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (seg_a == 7'h00 || seg_b == 7'h00) n8++;
    end
    check("glitch_no_8", n8, 0);
    bcd_lo = 4'd8;
    next_frame();
    frame_window(16);
    check("hold8_units", wcount(0, 2'b10, 7'h00), 6);

    // Error digit, sticky err.
    set_bcd(4'd0, 4'd12);
    next_frame();
    frame_window(16);
    check("err_dash", wcount(0, 2'b10, 7'h3F), 6);
    check("err_set", err_a, 1'b1);
    set_bcd(4'd0, 4'd5);
    next_frame();
    frame_window(16);
    check("err_units5", wcount(0, 2'b10, 7'h12), 6);
    check("err_sticky", err_a, 1'b1);

    // en dropped mid-SHOW of the units slot.
    repeat (4) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("endrop_first", an_a, 2'b10);
    @(negedge clk);
    check("endrop_second_an", an_a, 2'b11);
    check("endrop_second_seg", seg_a, 7'h7F);
    repeat (3) @(negedge clk);
    check("err_before_rst", err_a, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rst_clears_err", err_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of a frame.
    en = 1'b1;
    wait_tick();
    repeat (5) @(negedge clk);
    check("pre_rst_an", an_a, 2'b10);
    #1 rst = 1'b1;
    #1;
    check("async_seg", seg_a, 7'h7F);
    check("async_an", an_a, 2'b11);
    check("async_tick", tick_a, 1'b0);
    check("async_err", err_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_tick();
    @(negedge clk);
    wait_tick();
    frame_window(16);
    check("restart_units", wcount(0, 2'b10, 7'h12), 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
